// File: rtl/riscv_core_dcache_data_array_nway.sv
// N-way set-associative D-cache data array.
// Every port shares the same set, way and word decode.
// Load, store, refill and evict may all be issued on the same edge.
// Loads and evicts return registered data that was read before any write on that edge.
// The array has an asynchronous reset that clears every entry, so it is built from flops.
module riscv_core_dcache_data_array_nway #(
   parameter int WAYS            = 2,
   parameter int INDEX_WIDTH     = 7,
   parameter int BLOCK_OFFSET    = 2,
   parameter int CORE_DATA_WIDTH = 64,
   parameter int ADDR_WIDTH      = 64,
   parameter int AXI_DATA_WIDTH  = 256
) (
   input  logic                                     i_clk,
   input  logic                                     i_rst_n,
   input  logic [ADDR_WIDTH-1:0]                    i_addr,
   input  logic [63:0]                              i_wdata,
   input  logic [1:0]                               i_size,
   input  logic                                     i_unsigned,
   input  logic                                     i_rd_en,
   input  logic                                     i_wr_en,
   input  logic                                     i_block_replace,
   input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] i_way_sel,
   input  logic [AXI_DATA_WIDTH-1:0]                i_block_from_axi,
   input  logic                                     i_evict_rd_en,
   output logic [63:0]                              o_rdata,
   output logic                                     o_rvalid,
   output logic [AXI_DATA_WIDTH-1:0]                o_evict_block,
   output logic                                     o_evict_valid,
   output logic                                     o_misaligned
);

   localparam int SETS   = 1 << INDEX_WIDTH;
   localparam int DWORDS = 1 << BLOCK_OFFSET;
   localparam int WSEL_W = (BLOCK_OFFSET > 0) ? BLOCK_OFFSET : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int IDX_LO = BLOCK_OFFSET + 3;

   // Stop elaboration when the block width does not match the doublewords per block.
   // Stop it as well when the core data width is not 64.
   generate
      if (AXI_DATA_WIDTH != DWORDS * 64) begin : g_bad_block_width
         $error("AXI_DATA_WIDTH must equal 2**BLOCK_OFFSET * 64");
      end
      if (CORE_DATA_WIDTH != 64) begin : g_bad_core_width
         $error("CORE_DATA_WIDTH must be 64");
      end
   endgenerate

   logic [AXI_DATA_WIDTH-1:0] mem [WAYS][SETS];

   logic [2:0]               byte_off;
   logic [WSEL_W-1:0]        word_sel;
   logic [INDEX_WIDTH-1:0]   set_idx;
   logic [WAY_W-1:0]         way;
   logic [AXI_DATA_WIDTH-1:0] cur_blk;
   logic [63:0]              cur_dword;
   logic [63:0]              shifted;
   logic [63:0]              load_ext;
   logic [63:0]              size_mask;
   logic [63:0]              byte_mask;
   logic [63:0]              store_dword;
   logic                     misaligned;
   logic                     unused_addr_bits;

   logic [63:0]               rdata_reg;
   logic                      rvalid_reg;
   logic                      misaligned_reg;
   logic [AXI_DATA_WIDTH-1:0] evict_block_reg;
   logic                      evict_valid_reg;

   // The controller performs the tag compare, so address bits above the index are not used here.
   assign unused_addr_bits = ^i_addr[ADDR_WIDTH-1:INDEX_WIDTH+IDX_LO];

   assign byte_off = i_addr[2:0];
   assign set_idx  = i_addr[INDEX_WIDTH+IDX_LO-1:IDX_LO];

   generate
      if (BLOCK_OFFSET > 0) begin : g_word_sel
         assign word_sel = i_addr[BLOCK_OFFSET+2:3];
      end else begin : g_word_sel_single
         assign word_sel = '0;
      end
      if (WAYS > 1) begin : g_way_sel
         assign way = i_way_sel;
      end else begin : g_way_single
         logic unused_way_sel;
         assign unused_way_sel = ^i_way_sel;
         assign way = '0;
      end
   endgenerate

   // Current contents of the addressed block and doubleword, before any write on this edge.
   assign cur_blk   = mem[way][set_idx];
   assign cur_dword = cur_blk[word_sel*64 +: 64];
   assign shifted   = cur_dword >> {byte_off, 3'b000};

   // Alignment check: the byte offset must be a multiple of the access size.
   always_comb begin
      misaligned = 1'b0;
      case (i_size)
         2'b01:   misaligned = byte_off[0];
         2'b10:   misaligned = |byte_off[1:0];
         2'b11:   misaligned = |byte_off;
         default: misaligned = 1'b0;
      endcase
   end

   // Right-align the loaded bytes, then apply sign or zero extension.
   always_comb begin
      load_ext = shifted;
      case (i_size)
         2'b00:   load_ext = {{56{~i_unsigned & shifted[7]}},  shifted[7:0]};
         2'b01:   load_ext = {{48{~i_unsigned & shifted[15]}}, shifted[15:0]};
         2'b10:   load_ext = {{32{~i_unsigned & shifted[31]}}, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   // Byte-lane mask for a store, positioned at the byte offset (little-endian).
   always_comb begin
      size_mask = '1;
      case (i_size)
         2'b00:   size_mask = 64'h0000_0000_0000_00FF;
         2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = '1;
      endcase
   end

   assign byte_mask   = size_mask << {byte_off, 3'b000};
   assign store_dword = (cur_dword & ~byte_mask) | ((i_wdata << {byte_off, 3'b000}) & byte_mask);

   // Array update: a refill writes the whole block; an aligned store merges its bytes into one doubleword.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               mem[w][s] <= '0;
            end
         end
      end else if (i_wr_en) begin
         if (i_block_replace) begin
            mem[way][set_idx] <= i_block_from_axi;
         end else if (!misaligned) begin
            mem[way][set_idx][word_sel*64 +: 64] <= store_dword;
         end
      end
   end

   // Load and misalignment result registers; read data holds its value between loads.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_reg      <= '0;
         rvalid_reg     <= 1'b0;
         misaligned_reg <= 1'b0;
      end else begin
         rvalid_reg     <= i_rd_en;
         misaligned_reg <= misaligned & (i_rd_en | (i_wr_en & ~i_block_replace));
         if (i_rd_en) begin
            rdata_reg <= misaligned ? 64'd0 : load_ext;
         end
      end
   end

   // Victim-block read port for dirty writeback; the block holds its value between pulses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         evict_block_reg <= '0;
         evict_valid_reg <= 1'b0;
      end else begin
         evict_valid_reg <= i_evict_rd_en;
         if (i_evict_rd_en) begin
            evict_block_reg <= cur_blk;
         end
      end
   end

   assign o_rdata       = rdata_reg;
   assign o_rvalid      = rvalid_reg;
   assign o_misaligned  = misaligned_reg;
   assign o_evict_block = evict_block_reg;
   assign o_evict_valid = evict_valid_reg;

endmodule

// File: tb/tb_riscv_core_dcache_data_array_nway.sv
// Self-checking bench for riscv_core_dcache_data_array_nway.
// The reference model is a byte-addressed array indexed by [way][set][byte].
// Expected values are computed from that array before each edge, so reads see the pre-write contents.
module tb_riscv_core_dcache_data_array_nway;

   localparam int WAYS = 2;
   localparam int IW   = 7;
   localparam int BO   = 2;
   localparam int BW   = 256;
   localparam int NB   = BW / 8;
   localparam int SETS = 1 << IW;

   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b0;
   logic [63:0]    i_addr = '0;
   logic [63:0]    i_wdata = '0;
   logic [1:0]     i_size = '0;
   logic           i_unsigned = 1'b0;
   logic           i_rd_en = 1'b0;
   logic           i_wr_en = 1'b0;
   logic           i_block_replace = 1'b0;
   logic [0:0]     i_way_sel = '0;
   logic [BW-1:0]  i_block_from_axi = '0;
   logic           i_evict_rd_en = 1'b0;
   logic [63:0]    o_rdata;
   logic           o_rvalid;
   logic [BW-1:0]  o_evict_block;
   logic           o_evict_valid;
   logic           o_misaligned;

   always #5 i_clk = ~i_clk;

   riscv_core_dcache_data_array_nway #(
      .WAYS(WAYS), .INDEX_WIDTH(IW), .BLOCK_OFFSET(BO),
      .CORE_DATA_WIDTH(64), .ADDR_WIDTH(64), .AXI_DATA_WIDTH(BW)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_size(i_size), .i_unsigned(i_unsigned), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
      .i_block_replace(i_block_replace), .i_way_sel(i_way_sel),
      .i_block_from_axi(i_block_from_axi), .i_evict_rd_en(i_evict_rd_en),
      .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_evict_block(o_evict_block),
      .o_evict_valid(o_evict_valid), .o_misaligned(o_misaligned)
   );

   logic [7:0]    mb [WAYS][SETS][NB];
   logic [63:0]   exp_rdata = '0;
   logic          exp_rvalid = 1'b0;
   logic          exp_mis = 1'b0;
   logic          exp_evalid = 1'b0;
   logic [BW-1:0] exp_eblk = '0;
   int            n_assert = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      for (int w = 0; w < WAYS; w++)
         for (int s = 0; s < SETS; s++)
            for (int b = 0; b < NB; b++)
               mb[w][s][b] = 8'h00;
   endtask

   // Read n bytes little-endian from the model, then sign- or zero-extend them to 64 bits.
   function automatic logic [63:0] ref_load(int w, int ix, int base, int n, bit uns);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(mb[w][ix][base+i]) << (8*i));
      if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      return v;
   endfunction

   task automatic set_ld(input logic [63:0] a, input logic [1:0] sz, input bit uns, input int w);
      i_addr = a; i_size = sz; i_unsigned = uns; i_way_sel = 1'(w); i_rd_en = 1'b1;
   endtask

   task automatic set_st(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d, input int w);
      i_addr = a; i_size = sz; i_wdata = d; i_way_sel = 1'(w); i_wr_en = 1'b1; i_block_replace = 1'b0;
   endtask

   task automatic set_rf(input logic [63:0] a, input logic [BW-1:0] blk, input int w);
      i_addr = a; i_block_from_axi = blk; i_way_sel = 1'(w); i_wr_en = 1'b1; i_block_replace = 1'b1;
   endtask

   task automatic set_ev(input logic [63:0] a, input int w);
      i_addr = a; i_way_sel = 1'(w); i_evict_rd_en = 1'b1;
   endtask

   // One clock cycle. Expected outputs come from the pre-write model; the model is then updated and every output is checked.
   task automatic cycle(input string tag);
      int w, ix, wd, off, n;
      bit mis;
      w   = int'(i_way_sel);
      ix  = int'((i_addr >> (BO + 3)) % SETS);
      wd  = int'((i_addr >> 3) % (1 << BO));
      off = int'(i_addr % 8);
      n   = 1 << i_size;
      mis = (i_addr % n) != 0;
      exp_rvalid = i_rd_en;
      exp_evalid = i_evict_rd_en;
      exp_mis    = mis && (i_rd_en || (i_wr_en && !i_block_replace));
      if (i_rd_en) exp_rdata = mis ? 64'd0 : ref_load(w, ix, wd*8 + off, n, i_unsigned);
      if (i_evict_rd_en)
         for (int b = 0; b < NB; b++) exp_eblk[8*b +: 8] = mb[w][ix][b];
      if (i_wr_en && i_block_replace)
         for (int b = 0; b < NB; b++) mb[w][ix][b] = i_block_from_axi[8*b +: 8];
      else if (i_wr_en && !mis)
         for (int i = 0; i < n; i++) mb[w][ix][wd*8 + off + i] = i_wdata[8*i +: 8];
      @(posedge i_clk);
      #1;
      check({tag, ".rvalid"}, BW'(o_rvalid), BW'(exp_rvalid));
      check({tag, ".rdata"}, BW'(o_rdata), BW'(exp_rdata));
      check({tag, ".misaligned"}, BW'(o_misaligned), BW'(exp_mis));
      check({tag, ".evict_valid"}, BW'(o_evict_valid), BW'(exp_evalid));
      check({tag, ".evict_block"}, o_evict_block, exp_eblk);
      i_rd_en = 1'b0; i_wr_en = 1'b0; i_block_replace = 1'b0; i_evict_rd_en = 1'b0;
   endtask

   initial begin
      logic [BW-1:0] blk;
      logic [63:0]   a;
      model_clear();
      repeat (3) @(posedge i_clk);
      #1;
      check("reset.rvalid", BW'(o_rvalid), BW'(1'b0));
      check("reset.rdata", BW'(o_rdata), BW'(64'd0));
      check("reset.misaligned", BW'(o_misaligned), BW'(1'b0));
      check("reset.evict_valid", BW'(o_evict_valid), BW'(1'b0));
      check("reset.evict_block", o_evict_block, '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Refill way1 at 0x40, where doubleword k holds k+1; then load it back from both ways.
      blk = {64'd4, 64'd3, 64'd2, 64'd1};
      set_rf(64'h40, blk, 1);                   cycle("refill_w1");
      set_ld(64'h58, 2'b11, 1'b0, 1);           cycle("ld_w1_58");
      check("ld_w1_58.const", BW'(o_rdata), BW'(64'h4));
      set_ld(64'h58, 2'b11, 1'b0, 0);           cycle("ld_w0_58");
      check("ld_w0_58.const", BW'(o_rdata), BW'(64'h0));

      // Store a doubleword, then read it back with several sizes and both extension modes.
      set_st(64'h40, 2'b11, 64'h1122334455667788, 0); cycle("st_dw_40");
      set_ld(64'h47, 2'b00, 1'b0, 0);           cycle("ld_b_47_s");
      check("ld_b_47_s.const", BW'(o_rdata), BW'(64'h11));
      set_ld(64'h40, 2'b00, 1'b0, 0);           cycle("ld_b_40_s");
      check("ld_b_40_s.const", BW'(o_rdata), BW'(64'hFFFFFFFFFFFFFF88));
      set_ld(64'h40, 2'b00, 1'b1, 0);           cycle("ld_b_40_u");
      check("ld_b_40_u.const", BW'(o_rdata), BW'(64'h88));
      set_ld(64'h40, 2'b10, 1'b1, 0);           cycle("ld_w_40_u");
      check("ld_w_40_u.const", BW'(o_rdata), BW'(64'h55667788));
      set_ld(64'h46, 2'b01, 1'b0, 0);           cycle("ld_h_46_s");
      check("ld_h_46_s.const", BW'(o_rdata), BW'(64'h1122));

      // Misaligned store and misaligned load.
      set_st(64'h43, 2'b01, 64'hBEEF, 0);       cycle("st_h_43_mis");
      check("st_h_43_mis.flag", BW'(o_misaligned), BW'(1'b1));
      set_ld(64'h42, 2'b10, 1'b0, 0);           cycle("ld_w_42_mis");
      check("ld_w_42_mis.flag", BW'({o_rvalid, o_misaligned, o_rdata}), BW'({1'b1, 1'b1, 64'd0}));
      set_ld(64'h40, 2'b11, 1'b0, 0);           cycle("ld_after_mis");
      check("ld_after_mis.const", BW'(o_rdata), BW'(64'h1122334455667788));

      // Read during write on the same edge: the load sees the old data, and the next load sees the new data.
      set_st(64'h40, 2'b11, 64'h11223344556677AA, 0);
      set_ld(64'h40, 2'b11, 1'b0, 0);           cycle("rdw_same_edge");
      check("rdw_same_edge.const", BW'(o_rdata), BW'(64'h1122334455667788));
      set_ld(64'h40, 2'b11, 1'b0, 0);           cycle("rdw_next");
      check("rdw_next.const", BW'(o_rdata), BW'(64'h11223344556677AA));

      // Evict and load issued together, then an evict on the same edge as a refill.
      set_ev(64'h58, 1);
      set_ld(64'h58, 2'b11, 1'b0, 1);           cycle("ev_ld_w1");
      check("ev_ld_w1.const", o_evict_block, blk);
      set_ev(64'h40, 0);
      set_rf(64'h40, {8{32'hCAFE0000}}, 0);     cycle("ev_refill_w0");
      check("ev_refill_w0.const", o_evict_block[63:0], BW'(64'h11223344556677AA));
      set_ev(64'h40, 0);                        cycle("ev_after_refill");
      check("ev_after_refill.const", o_evict_block, {8{32'hCAFE0000}});
      cycle("idle_hold");

      // Assert reset between a load request and its result.
      set_ld(64'h40, 2'b11, 1'b0, 0);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      check("rst_async.rdata", BW'(o_rdata), BW'(64'd0));
      check("rst_async.evict_block", o_evict_block, '0);
      @(posedge i_clk);
      #1;
      check("rst_mid.rvalid", BW'(o_rvalid), BW'(1'b0));
      check("rst_mid.misaligned", BW'(o_misaligned), BW'(1'b0));
      i_rd_en = 1'b0;
      model_clear();
      exp_rdata = '0; exp_eblk = '0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      set_ld(64'h40, 2'b11, 1'b0, 0);           cycle("post_rst_w0");
      check("post_rst_w0.const", BW'(o_rdata), BW'(64'd0));

      // Back-to-back loads: one result per cycle.
      set_st(64'h40, 2'b11, 64'hA0A0A0A0A0A0A0A0, 0); cycle("b2b_st0");
      set_st(64'h48, 2'b11, 64'hB1B1B1B1B1B1B1B1, 0); cycle("b2b_st1");
      set_st(64'h50, 2'b11, 64'hC2C2C2C2C2C2C2C2, 0); cycle("b2b_st2");
      set_ld(64'h40, 2'b11, 1'b0, 0);           cycle("b2b_ld0");
      set_ld(64'h48, 2'b11, 1'b0, 0);           cycle("b2b_ld1");
      set_ld(64'h50, 2'b11, 1'b0, 0);           cycle("b2b_ld2");
      check("b2b_ld2.const", BW'(o_rdata), BW'(64'hC2C2C2C2C2C2C2C2));

      // Random mix of all ports across a few sets, with random upper address bits.
      for (int t = 0; t < 400; t++) begin
         a = {$urandom, $urandom};
         a[11:7] = '0;
         i_addr = a;
         i_size = 2'($urandom_range(0, 3));
         i_unsigned = 1'($urandom);
         i_way_sel = 1'($urandom);
         i_wdata = {$urandom, $urandom};
         for (int k = 0; k < BW/32; k++) i_block_from_axi[32*k +: 32] = $urandom;
         i_rd_en = ($urandom_range(0, 1) == 1);
         i_wr_en = ($urandom_range(0, 9) < 4);
         i_block_replace = i_wr_en && ($urandom_range(0, 3) == 0);
         i_evict_rd_en = ($urandom_range(0, 3) == 0);
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
